dma_burst_planner: RTL and testbench
====================================

// Module: dma_burst_planner
// PURPOSE
//   Sits between the DMA descriptor load stage (LOAD_DESC) and the AXI4 read/write address issuers.
//   Takes one accepted descriptor (src, dst, byte length, width, inc/burst flags) and splits it
//   into a sequence of AXI4 burst commands (CALC_BURST). Each command carries paired src/dst addresses,
//   AxLEN, AxSIZE and AxBURST, obeys MAX_BURST_LEN and never crosses a 4 KB boundary on an INCR side.
// PARAMETERS
//   ADDR_W    32    address width (matches AXI_ADDR_WIDTH)
//   LEN_W     32    descriptor byte-length width
//   MAX_BEATS 16    max beats per burst (MAX_BURST_LEN); legal range 1..256
//   BOUNDARY  4096  INCR bursts must not cross this byte boundary; power of two
// PORTS
//   clk           in   1       single clock
//   rst           in   1       synchronous, active-high reset
//   desc_valid    in   1       descriptor valid
//   desc_ready    out  1       descriptor accepted when valid&&ready
//   desc_src      in   ADDR_W  source byte address
//   desc_dst      in   ADDR_W  destination byte address
//   desc_len      in   LEN_W   total bytes
//   desc_width    in   2       transfer_width_e: 00 BYTE, 01 HALFWORD, 10 WORD, 11 illegal
//   desc_src_inc  in   1       1=INCR source, 0=FIXED
//   desc_dst_inc  in   1       1=INCR destination, 0=FIXED
//   desc_burst_en in   1       0 forces single-beat commands
//   abort         in   1       drop the current descriptor
//   cmd_valid     out  1       burst command valid
//   cmd_ready     in   1       consumer accepts command
//   cmd_src_addr  out  ADDR_W  burst source start address (ARADDR)
//   cmd_dst_addr  out  ADDR_W  burst destination start address (AWADDR)
//   cmd_len       out  8       beats-1 (AxLEN)
//   cmd_size      out  3       AxSIZE = desc_width zero-extended
//   cmd_src_burst out  2       axi_burst_e: INCR 01 / FIXED 00
//   cmd_dst_burst out  2       axi_burst_e: INCR 01 / FIXED 00
//   cmd_last      out  1       final command of the descriptor
//   busy          out  1       high in every state except IDLE
//   done          out  1       one-cycle pulse after handshake of the last command
//   err           out  1       one-cycle pulse when a descriptor is rejected
// BEHAVIOUR
//   Reset: state IDLE. desc_ready=1. cmd_valid, busy, done and err are 0. All cmd_* registers are 0.
//   States: IDLE -> CHECK -> CALC -> ISSUE -> (CALC | IDLE).
//   IDLE: desc_ready=1. On a handshake, latch the descriptor and go to CHECK. desc_ready is 0 in all other states.
//   CHECK: B = 1<<width. Reject the descriptor if any of these hold:
//     width==11; len==0; len%B!=0; src%B!=0; dst%B!=0.
//     On reject: err=1 for one cycle, return to IDLE, no command issued. Otherwise go to CALC, rem_beats = len>>width.
//   CALC computes beats = min(rem_beats, cap, src_lim, dst_lim).
//     cap = burst_en ? MAX_BEATS : 1.
//     side_lim = (BOUNDARY - addr % BOUNDARY) >> width on an INCR side; MAX_BEATS on a FIXED side.
//     beats>=1 is guaranteed by alignment. Register the cmd_* outputs; cmd_last = (beats==rem_beats). Go to ISSUE.
//   ISSUE: cmd_valid=1. cmd_* fields stay stable until cmd_ready.
//     On handshake: rem_beats -= beats; each INCR address += beats<<width; FIXED addresses are unchanged.
//     If cmd_last: done=1 next cycle and go to IDLE. Otherwise go to CALC.
//   Latency: desc handshake at cycle N -> first cmd_valid at N+3. One bubble cycle (CALC) between commands.
//   abort (any state): next cycle IDLE, cmd_valid=0, no done/err. abort has priority over a same-cycle cmd handshake.
//   rst mid-burst: same values as power-on reset; the partial descriptor is discarded.
//   Address arithmetic wraps modulo 2^ADDR_W. rem_beats is LEN_W bits wide.
// TESTING
//   1. src=0x1000 dst=0x2000 len=256 WORD inc/inc burst -> 4 cmds, len=15, src 0x1000/1040/1080/10C0, last on 4th, done
//   2. src=0x0FF8 dst=0x3000 len=64 WORD -> cmd0 len=1 @0x0FF8/0x3000; cmd1 len=13 @0x1000/0x3008, last
//   3. len=12 BYTE burst_en=0 -> 12 cmds, each len=0 size=0; addresses step by 1; done after the 12th
//   4. dst_inc=0 dst=0x4000 len=128 WORD -> 2 cmds len=15, dst_burst=00 and dst=0x4000 both times
//   5. width=11, or len=6 WORD, or src=0x1002 WORD -> err pulse, cmd_valid never asserted, desc_ready=1 next
//   6. cmd_ready held low 5 cycles -> cmd_* stable; abort or rst during ISSUE -> cmd_valid=0 next cycle, IDLE

Source files
------------

// File: rtl/dma_burst_planner.sv
// Splits one DMA descriptor into a sequence of AXI4 burst commands, honouring
// the beat cap and never letting an INCR side cross the address boundary.
module dma_burst_planner #(
    parameter int ADDR_W    = 32,
    parameter int LEN_W     = 32,
    parameter int MAX_BEATS = 16,
    parameter int BOUNDARY  = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              desc_valid,
    output logic              desc_ready,
    input  logic [ADDR_W-1:0] desc_src,
    input  logic [ADDR_W-1:0] desc_dst,
    input  logic [LEN_W-1:0]  desc_len,
    input  logic [1:0]        desc_width,
    input  logic              desc_src_inc,
    input  logic              desc_dst_inc,
    input  logic              desc_burst_en,
    input  logic              abort,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [ADDR_W-1:0] cmd_src_addr,
    output logic [ADDR_W-1:0] cmd_dst_addr,
    output logic [7:0]        cmd_len,
    output logic [2:0]        cmd_size,
    output logic [1:0]        cmd_src_burst,
    output logic [1:0]        cmd_dst_burst,
    output logic              cmd_last,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int OFF_W = $clog2(BOUNDARY);
    localparam int MW0   = (LEN_W > OFF_W + 1) ? LEN_W : OFF_W + 1;
    localparam int MW    = (MW0 > 9) ? MW0 : 9;

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_CALC, S_ISSUE} state_e;
    state_e state, state_nxt;

    logic [ADDR_W-1:0] src_q, dst_q;
    logic [LEN_W-1:0]  len_q, rem_q;
    logic [1:0]        width_q;
    logic              src_inc_q, dst_inc_q, burst_en_q;
    logic [8:0]        beats_q;
    logic [1:0]        mask;
    logic              reject, cmd_hs;
    logic [MW-1:0]     beats_c;

    function automatic logic [MW-1:0] min2(input logic [MW-1:0] a, input logic [MW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    // Beats left before the boundary on an INCR side; FIXED sides never limit.
    function automatic logic [MW-1:0] side_lim(input logic [OFF_W-1:0] off, input logic inc,
                                               input logic [1:0] w);
        if (inc) return (MW'(BOUNDARY) - MW'(off)) >> w;
        else     return MW'(MAX_BEATS);
    endfunction

    always_comb begin
        case (width_q)
            2'b00:   mask = 2'b00;
            2'b01:   mask = 2'b01;
            default: mask = 2'b11;
        endcase
        reject = (width_q == 2'b11) || (len_q == '0) || ((len_q[1:0] & mask) != 2'b00) ||
                 ((src_q[1:0] & mask) != 2'b00) || ((dst_q[1:0] & mask) != 2'b00);
        beats_c = min2(min2(MW'(rem_q), burst_en_q ? MW'(MAX_BEATS) : MW'(1)),
                       min2(side_lim(src_q[OFF_W-1:0], src_inc_q, width_q),
                            side_lim(dst_q[OFF_W-1:0], dst_inc_q, width_q)));
    end

    assign cmd_hs = (state == S_ISSUE) && cmd_ready && !abort;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (desc_valid) state_nxt = S_CHECK;
            S_CHECK: state_nxt = reject ? S_IDLE : S_CALC;
            S_CALC:  state_nxt = S_ISSUE;
            S_ISSUE: if (cmd_ready) state_nxt = cmd_last ? S_IDLE : S_CALC;
            default: state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    always_comb begin
        desc_ready = (state == S_IDLE);
        cmd_valid  = (state == S_ISSUE);
        busy       = (state != S_IDLE);
    end

    // Descriptor working copy; contents are don't-care while idle.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && desc_valid) begin
            src_q      <= desc_src;
            dst_q      <= desc_dst;
            len_q      <= desc_len;
            width_q    <= desc_width;
            src_inc_q  <= desc_src_inc;
            dst_inc_q  <= desc_dst_inc;
            burst_en_q <= desc_burst_en;
        end
        if (state == S_CHECK) rem_q <= len_q >> width_q;
        if (state == S_CALC)  beats_q <= 9'(beats_c);
        if (cmd_hs) begin
            rem_q <= rem_q - LEN_W'(beats_q);
            if (src_inc_q) src_q <= src_q + (ADDR_W'(beats_q) << width_q);
            if (dst_inc_q) dst_q <= dst_q + (ADDR_W'(beats_q) << width_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_src_addr  <= '0;
            cmd_dst_addr  <= '0;
            cmd_len       <= '0;
            cmd_size      <= '0;
            cmd_src_burst <= '0;
            cmd_dst_burst <= '0;
            cmd_last      <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            done <= cmd_hs && cmd_last;
            err  <= (state == S_CHECK) && reject && !abort;
            if (state == S_CALC) begin
                cmd_src_addr  <= src_q;
                cmd_dst_addr  <= dst_q;
                cmd_len       <= 8'(beats_c - MW'(1));
                cmd_size      <= {1'b0, width_q};
                cmd_src_burst <= src_inc_q ? 2'b01 : 2'b00;
                cmd_dst_burst <= dst_inc_q ? 2'b01 : 2'b00;
                cmd_last      <= (beats_c == MW'(rem_q));
            end
        end
    end
endmodule

// File: tb/tb_dma_burst_planner.sv
// Directed bench for dma_burst_planner: burst splitting, boundary limits,
// single-beat mode, FIXED sides, rejects, back-pressure, abort and reset.
module tb_dma_burst_planner;
    logic        clk = 1'b0;
    logic        rst, desc_valid, desc_ready;
    logic [31:0] desc_src, desc_dst, desc_len;
    logic [1:0]  desc_width;
    logic        desc_src_inc, desc_dst_inc, desc_burst_en, abort;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_src_addr, cmd_dst_addr;
    logic [7:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [1:0]  cmd_src_burst, cmd_dst_burst;
    logic        cmd_last, busy, done, err;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    dma_burst_planner dut (
        .clk(clk), .rst(rst), .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_src(desc_src), .desc_dst(desc_dst), .desc_len(desc_len), .desc_width(desc_width),
        .desc_src_inc(desc_src_inc), .desc_dst_inc(desc_dst_inc), .desc_burst_en(desc_burst_en),
        .abort(abort), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src_addr(cmd_src_addr), .cmd_dst_addr(cmd_dst_addr), .cmd_len(cmd_len),
        .cmd_size(cmd_size), .cmd_src_burst(cmd_src_burst), .cmd_dst_burst(cmd_dst_burst),
        .cmd_last(cmd_last), .busy(busy), .done(done), .err(err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns at the negedge following the handshake edge (DUT in CHECK).
    task automatic send_desc(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                             input logic [1:0] w, input logic si, input logic di, input logic be);
        @(negedge clk);
        desc_valid = 1'b1; desc_src = s; desc_dst = d; desc_len = l; desc_width = w;
        desc_src_inc = si; desc_dst_inc = di; desc_burst_en = be;
        @(negedge clk);
        desc_valid = 1'b0;
    endtask

    // With adv set: one bubble cycle with cmd_valid low, then cmd_valid on the next.
    task automatic expect_cmd(input string tag, input bit adv, input logic [31:0] s,
                              input logic [31:0] d, input logic [7:0] l, input logic [2:0] sz,
                              input logic [1:0] sb, input logic [1:0] db, input logic last);
        if (adv) begin
            @(negedge clk);
            chk({tag, " bubble"}, cmd_valid, 1'b0);
            @(negedge clk);
        end
        chk({tag, " valid"}, cmd_valid, 1'b1);
        chk({tag, " src"}, cmd_src_addr, s);
        chk({tag, " dst"}, cmd_dst_addr, d);
        chk({tag, " len"}, cmd_len, l);
        chk({tag, " size"}, cmd_size, sz);
        chk({tag, " sburst"}, cmd_src_burst, sb);
        chk({tag, " dburst"}, cmd_dst_burst, db);
        chk({tag, " last"}, cmd_last, last);
    endtask

    task automatic expect_done(input string tag);
        @(negedge clk);
        chk({tag, " done"}, done, 1'b1);
        chk({tag, " busy"}, busy, 1'b0);
        @(negedge clk);
        chk({tag, " done pulse"}, done, 1'b0);
        chk({tag, " ready"}, desc_ready, 1'b1);
    endtask

    task automatic expect_err(input string tag);
        chk({tag, " no cmd"}, cmd_valid, 1'b0);
        @(negedge clk);
        chk({tag, " err"}, err, 1'b1);
        chk({tag, " ready"}, desc_ready, 1'b1);
        chk({tag, " valid"}, cmd_valid, 1'b0);
        @(negedge clk);
        chk({tag, " err pulse"}, err, 1'b0);
        chk({tag, " done"}, done, 1'b0);
    endtask

    initial begin
        rst = 1'b1; desc_valid = 1'b0; desc_src = '0; desc_dst = '0; desc_len = '0;
        desc_width = '0; desc_src_inc = 1'b1; desc_dst_inc = 1'b1; desc_burst_en = 1'b1;
        abort = 1'b0; cmd_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst ready", desc_ready, 1'b1);
        chk("rst valid", cmd_valid, 1'b0);
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst err", err, 1'b0);
        chk("rst src", cmd_src_addr, 32'h0);
        chk("rst len", cmd_len, 8'h0);

        // Four full 16-beat word bursts
        send_desc(32'h1000, 32'h2000, 32'd256, 2'b10, 1'b1, 1'b1, 1'b1);
        chk("t1 check busy", busy, 1'b1);
        chk("t1 check ready", desc_ready, 1'b0);
        expect_cmd("t1c0", 1'b1, 32'h1000, 32'h2000, 8'd15, 3'd2, 2'b01, 2'b01, 1'b0);
        expect_cmd("t1c1", 1'b1, 32'h1040, 32'h2040, 8'd15, 3'd2, 2'b01, 2'b01, 1'b0);
        expect_cmd("t1c2", 1'b1, 32'h1080, 32'h2080, 8'd15, 3'd2, 2'b01, 2'b01, 1'b0);
        expect_cmd("t1c3", 1'b1, 32'h10C0, 32'h20C0, 8'd15, 3'd2, 2'b01, 2'b01, 1'b1);
        expect_done("t1");

        // Source 8 bytes below a 4 KB boundary: 2 beats, then the remaining 14
        send_desc(32'h0FF8, 32'h3000, 32'd64, 2'b10, 1'b1, 1'b1, 1'b1);
        expect_cmd("t2c0", 1'b1, 32'h0FF8, 32'h3000, 8'd1, 3'd2, 2'b01, 2'b01, 1'b0);
        expect_cmd("t2c1", 1'b1, 32'h1000, 32'h3008, 8'd13, 3'd2, 2'b01, 2'b01, 1'b1);
        expect_done("t2");

        // burst_en=0: twelve single-byte commands
        send_desc(32'h0100, 32'h0200, 32'd12, 2'b00, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++)
            expect_cmd($sformatf("t3c%0d", i), 1'b1, 32'h0100 + i, 32'h0200 + i, 8'd0, 3'd0,
                       2'b01, 2'b01, i == 11);
        expect_done("t3");

        // FIXED destination stays put and limits bursts only by the beat cap
        send_desc(32'h5000, 32'h4000, 32'd128, 2'b10, 1'b1, 1'b0, 1'b1);
        expect_cmd("t4c0", 1'b1, 32'h5000, 32'h4000, 8'd15, 3'd2, 2'b01, 2'b00, 1'b0);
        expect_cmd("t4c1", 1'b1, 32'h5040, 32'h4000, 8'd15, 3'd2, 2'b01, 2'b00, 1'b1);
        expect_done("t4");

        // Rejected descriptors
        send_desc(32'h1000, 32'h2000, 32'd4, 2'b11, 1'b1, 1'b1, 1'b1);
        expect_err("t5 width");
        send_desc(32'h1000, 32'h2000, 32'd6, 2'b10, 1'b1, 1'b1, 1'b1);
        expect_err("t5 len");
        send_desc(32'h1002, 32'h2000, 32'd8, 2'b10, 1'b1, 1'b1, 1'b1);
        expect_err("t5 src");
        send_desc(32'h1000, 32'h2000, 32'd0, 2'b00, 1'b1, 1'b1, 1'b1);
        expect_err("t5 zero");

        // Back-pressure: fields hold while cmd_ready is low
        cmd_ready = 1'b0;
        send_desc(32'h1000, 32'h2000, 32'd128, 2'b10, 1'b1, 1'b1, 1'b1);
        expect_cmd("t6 hold0", 1'b1, 32'h1000, 32'h2000, 8'd15, 3'd2, 2'b01, 2'b01, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            expect_cmd($sformatf("t6 hold%0d", i), 1'b0, 32'h1000, 32'h2000, 8'd15, 3'd2,
                       2'b01, 2'b01, 1'b0);
        end
        cmd_ready = 1'b1;
        expect_cmd("t6c1", 1'b1, 32'h1040, 32'h2040, 8'd15, 3'd2, 2'b01, 2'b01, 1'b1);
        expect_done("t6");

        // Abort wins over a simultaneous handshake of the last command
        cmd_ready = 1'b0;
        send_desc(32'h1000, 32'h2000, 32'd16, 2'b10, 1'b1, 1'b1, 1'b1);
        expect_cmd("t6a", 1'b1, 32'h1000, 32'h2000, 8'd3, 3'd2, 2'b01, 2'b01, 1'b1);
        abort = 1'b1; cmd_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t6a valid", cmd_valid, 1'b0);
        chk("t6a busy", busy, 1'b0);
        chk("t6a ready", desc_ready, 1'b1);
        chk("t6a done", done, 1'b0);
        @(negedge clk);
        chk("t6a done later", done, 1'b0);
        chk("t6a err", err, 1'b0);

        // Reset during ISSUE clears everything back to power-on values
        cmd_ready = 1'b0;
        send_desc(32'h1000, 32'h2000, 32'd256, 2'b10, 1'b1, 1'b1, 1'b1);
        expect_cmd("t6r", 1'b1, 32'h1000, 32'h2000, 8'd15, 3'd2, 2'b01, 2'b01, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; cmd_ready = 1'b1;
        chk("t6r valid", cmd_valid, 1'b0);
        chk("t6r busy", busy, 1'b0);
        chk("t6r src", cmd_src_addr, 32'h0);
        chk("t6r len", cmd_len, 8'h0);
        chk("t6r last", cmd_last, 1'b0);

        // Planner is usable again after abort/reset
        send_desc(32'h8000, 32'h9000, 32'd8, 2'b01, 1'b1, 1'b1, 1'b1);
        expect_cmd("t7c0", 1'b1, 32'h8000, 32'h9000, 8'd3, 3'd1, 2'b01, 2'b01, 1'b1);
        expect_done("t7");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
